// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state and error encodings shared by the boot loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam int HDR_BYTES = 2;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs big-endian bytes into 32-bit words, one-cycle word_valid.
module imem_word_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  lane_q;
    logic [23:0] sr_q;

    assign last_o = lane_q == 2'd3;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q       <= '0;
            sr_q         <= '0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
        end else begin
            word_valid_o <= en_i && last_o && !clr_i;
            if (clr_i) begin
                lane_q <= '0;
                sr_q   <= '0;
            end else if (en_i) begin
                lane_q <= lane_q + 2'd1;
                sr_q   <= {sr_q[15:0], byte_i};
                if (last_o) word_o <= {sr_q, byte_i};
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader writing IM and holding the CPU
// in reset until the image checksum verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_e                   state_q;
    logic [HDR_BYTES*8-1:0]   cnt_q;
    logic [7:0]               sum_q;
    logic [16:0]              wcnt_q;
    logic                     xfer, start_ok, last;
    logic [7:0]               sum_nxt;
    logic [16:0]              n_hdr, wcnt_nxt;

    assign xfer     = in_valid_i && in_ready_o;
    assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign sum_nxt  = sum_q + in_data_i;
    assign n_hdr    = {1'b0, cnt_q[15:8], in_data_i};
    assign wcnt_nxt = wcnt_q + 17'd1;

    imem_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (start_ok),
        .en_i        (xfer && state_q == S_DATA),
        .byte_i      (in_data_i),
        .last_o      (last),
        .word_valid_o(im_we_o),
        .word_o      (im_wdata_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            wcnt_q     <= '0;
            in_ready_o <= 1'b0;
            im_addr_o  <= '0;
            cpu_hold_o <= HOLD_AT_RESET;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (start_i) begin
                    state_q    <= S_HDR_HI;
                    sum_q      <= '0;
                    wcnt_q     <= '0;
                    in_ready_o <= 1'b1;
                    cpu_hold_o <= 1'b1;
                    done_o     <= 1'b0;
                    err_o      <= 1'b0;
                    err_code_o <= ERR_NONE;
                end
                S_HDR_HI: if (xfer) begin
                    cnt_q[15:8] <= in_data_i;
                    sum_q       <= sum_nxt;
                    state_q     <= S_HDR_LO;
                end
                S_HDR_LO: if (xfer) begin
                    cnt_q[7:0] <= in_data_i;
                    sum_q      <= sum_nxt;
                    if (n_hdr > DEPTH) begin
                        state_q    <= S_ERR;
                        in_ready_o <= 1'b0;
                        err_o      <= 1'b1;
                        err_code_o <= ERR_OVF;
                    end else begin
                        state_q <= (n_hdr == 17'd0) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
                    sum_q <= sum_nxt;
                    if (last) begin
                        im_addr_o <= wcnt_q[ADDR_W-1:0];
                        wcnt_q    <= wcnt_nxt;
                        if (wcnt_nxt == {1'b0, cnt_q}) state_q <= S_CHK;
                    end
                end
                S_CHK: if (xfer) begin
                    in_ready_o <= 1'b0;
                    if (sum_nxt == 8'd0) begin
                        state_q    <= S_DONE;
                        done_o     <= 1'b1;
                        cpu_hold_o <= 1'b0;
                    end else begin
                        state_q    <= S_ERR;
                        err_o      <= 1'b1;
                        err_code_o <= ERR_CHK;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level reference model,
// with a queue scoreboard checking every IM write.
module tb_imem_loader;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, im_we, cpu_hold, done, err;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [1:0]    err_code;

    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;
    int gap_pct = 0;
    logic [AW+31:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .HOLD_AT_RESET(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .im_we_o(im_we), .im_addr_o(im_addr), .im_wdata_o(im_wdata),
        .cpu_hold_o(cpu_hold), .done_o(done), .err_o(err), .err_code_o(err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts handshakes and pops expected writes whenever IM is strobed.
    always @(negedge clk) begin
        if (in_valid && in_ready) xfers++;
        if (im_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h with empty scoreboard", im_addr, im_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("im_addr", 32'(im_addr), 32'(e[AW+31:32]));
                check("im_wdata", im_wdata, e[31:0]);
            end
        end
    end

    task automatic put_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) check("byte_accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_done", 32'(done), 0);
        check("start_err", 32'(err), 0);
        check("start_code", 32'(err_code), 0);
        check("start_hold", 32'(cpu_hold), 1);
        check("start_ready", 32'(in_ready), 1);
    endtask

    // Reference: frame bytes, checksum and outcome derived directly from the frame rules.
    task automatic run_frame(input logic [31:0] wq[$], input bit bad);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        int n, x0, nsend;
        bit ovf;
        n   = wq.size();
        ovf = n > DEPTH;
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        foreach (wq[i]) for (int k = 3; k >= 0; k--) bytes.push_back(wq[i][8*k +: 8]);
        sum = 8'h00;
        foreach (bytes[i]) sum = sum + bytes[i];
        bytes.push_back(8'(8'h00 - sum) + 8'(bad));
        if (!ovf) foreach (wq[i]) exp_q.push_back({AW'(i), wq[i]});
        do_start();
        x0 = xfers;
        nsend = ovf ? 2 : bytes.size();
        for (int i = 0; i < nsend; i++) put_byte(bytes[i]);
        if (ovf) begin
            check("ovf_err", 32'(err), 1);
            check("ovf_code", 32'(err_code), 32'(2'b01));
            in_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1 in_valid = 1'b0;
        end
        for (int t = 0; t < 20 && !(done || err); t++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("done", 32'(done), (!ovf && !bad) ? 1 : 0);
        check("err", 32'(err), (ovf || bad) ? 1 : 0);
        check("err_code", 32'(err_code), ovf ? 32'(2'b01) : bad ? 32'(2'b10) : 0);
        check("cpu_hold", 32'(cpu_hold), (!ovf && !bad) ? 0 : 1);
        check("in_ready_after", 32'(in_ready), 0);
        check("xfer_count", 32'(xfers - x0), ovf ? 2 : 3 + 4 * n);
        check("writes_pending", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_im_we", 32'(im_we), 0);
        check("rst_im_addr", 32'(im_addr), 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_cpu_hold", 32'(cpu_hold), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
    endtask

    function automatic void rand_words(output logic [31:0] wq[$], input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endfunction

    initial begin
        logic [31:0] wq[$];
        repeat (2) @(posedge clk);
        #1 check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 32'(in_ready), 0);
        check("idle_hold", 32'(cpu_hold), 1);

        wq = '{32'h20080005, 32'hAC090000};
        run_frame(wq, 1'b0);
        run_frame(wq, 1'b1);
        rand_words(wq, 17);
        run_frame(wq, 1'b0);
        gap_pct = 50;
        wq = '{32'h20080005, 32'hAC090000};
        run_frame(wq, 1'b0);
        rand_words(wq, DEPTH);
        run_frame(wq, 1'b0);
        gap_pct = 0;

        // Abort mid-DATA: address and data registers still hold the previous frame's last word.
        do_start();
        put_byte(8'h00); put_byte(8'h02); put_byte(8'h11); put_byte(8'h22); put_byte(8'h33);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        wq = '{32'hDEADBEEF, 32'h01234567};
        run_frame(wq, 1'b0);

        wq.delete();
        run_frame(wq, 1'b0);
        run_frame(wq, 1'b1);

        for (int r = 0; r < 8; r++) begin
            gap_pct = $urandom_range(0, 60);
            rand_words(wq, $urandom_range(0, DEPTH + 1));
            run_frame(wq, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
